// File: rtl/bus_bridge_xfer.sv
// Registered bridge between two bus segments: captures one side, broadcasts the word to both.
// Latency: broadcast/done in the LAT-th cycle after the capture edge; one transfer per LAT+1 cycles.
// Backpressure: none; requests are level-held, sampled only in IDLE, ignored while busy.
module bus_bridge_xfer #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus1_in,
    input  logic [WIDTH-1:0] bus2_in,
    input  logic             req_down,
    input  logic             req_up,
    output logic [WIDTH-1:0] bus1_out,
    output logic [WIDTH-1:0] bus2_out,
    output logic             busy,
    output logic             done,
    output logic             dir_q,
    output logic [CNT_W-1:0] xfer_cnt
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // XFER lasts LAT-1 cycles, so the wait counter starts at LAT-2; LAT=1 skips XFER entirely.
    localparam int         WAIT_INIT_I    = (LAT > 1) ? (LAT - 2) : 0;
    localparam logic [2:0] WAIT_INIT      = 3'(WAIT_INIT_I);
    localparam logic [1:0] ST_AFTER_GRANT = (LAT > 1) ? ST_XFER : ST_DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       wait_cnt;
    logic             last_down;
    logic             grant_vld;
    logic             grant_down;

    // Arbitration: a lone request wins; a tie goes opposite to the previous grant.
    always_comb begin
        grant_vld  = req_down | req_up;
        grant_down = req_down & ~(req_up & last_down);
    end

    // Transfer sequencing, holding register, grant history and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            wait_cnt  <= '0;
            dir_q     <= 1'b0;
            last_down <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        data_q    <= grant_down ? bus1_in : bus2_in;
                        dir_q     <= grant_down;
                        last_down <= grant_down;
                        wait_cnt  <= WAIT_INIT;
                        state     <= ST_AFTER_GRANT;
                    end
                end
                ST_XFER: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    xfer_cnt <= xfer_cnt + CNT_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status straight from the state register; segments see data_q only in the broadcast cycle.
    always_comb begin
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        bus1_out = done ? data_q : bus1_in;
        bus2_out = done ? data_q : bus2_in;
    end

endmodule

// File: tb/tb_bus_bridge_xfer.sv
// Bench for bus_bridge_xfer: three instances (LAT=1, LAT=4, LAT=3 with a 2-bit counter).
// A transaction-level model predicts each broadcast; a negedge monitor compares every cycle.
// Directed scenarios first, then randomized requests, data and occasional resets.
module tb_bus_bridge_xfer;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn [N];
    logic [31:0] b1 [N];
    logic [31:0] b2 [N];
    logic        rd [N];
    logic        ru [N];
    logic [31:0] o1 [N];
    logic [31:0] o2 [N];
    logic        busy_o [N];
    logic        done_o [N];
    logic        dir_o [N];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    bus_bridge_xfer #(.WIDTH(32), .LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rn[0]), .bus1_in(b1[0]), .bus2_in(b2[0]),
        .req_down(rd[0]), .req_up(ru[0]), .bus1_out(o1[0]), .bus2_out(o2[0]),
        .busy(busy_o[0]), .done(done_o[0]), .dir_q(dir_o[0]), .xfer_cnt(cnt0));

    bus_bridge_xfer #(.WIDTH(32), .LAT(4), .CNT_W(16)) u_l4 (
        .clk(clk), .rst_n(rn[1]), .bus1_in(b1[1]), .bus2_in(b2[1]),
        .req_down(rd[1]), .req_up(ru[1]), .bus1_out(o1[1]), .bus2_out(o2[1]),
        .busy(busy_o[1]), .done(done_o[1]), .dir_q(dir_o[1]), .xfer_cnt(cnt1));

    bus_bridge_xfer #(.WIDTH(32), .LAT(3), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rn[2]), .bus1_in(b1[2]), .bus2_in(b2[2]),
        .req_down(rd[2]), .req_up(ru[2]), .bus1_out(o1[2]), .bus2_out(o2[2]),
        .busy(busy_o[2]), .done(done_o[2]), .dir_q(dir_o[2]), .xfer_cnt(cnt2));

    int lat_m  [N] = '{1, 4, 3};
    int mask_m [N] = '{32'hFFFF, 32'hFFFF, 32'h3};

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb [N][$];
    int   cnt_m [N];
    logic dir_m [N];
    logic last_m [N];
    bit   pend_m [N];
    int   pend_due [N];
    int   free_m [N];

    int edge_no = 0;
    int total = 0;
    int bad = 0;

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, k, edge_no, act, expv);
        end
    endfunction

    // Drop every in-flight expectation and return the model to its reset picture.
    function automatic void reset_model(int k);
        rn[k]       = 1'b0;
        sb[k].delete();
        pend_m[k]   = 1'b0;
        pend_due[k] = 0;
        cnt_m[k]    = 0;
        dir_m[k]    = 1'b0;
        last_m[k]   = 1'b0;
        free_m[k]   = 0;
    endfunction

    // Transfer-level view of one clock edge: a grant at edge e broadcasts in cycle e+LAT-1,
    // completes at edge e+LAT, and the next grant may happen no earlier than edge e+LAT+1.
    function automatic void model_edge(int k);
        exp_t e;
        bit   down;
        if (!rn[k]) return;
        if (pend_m[k] && edge_no == pend_due[k] + 1) begin
            cnt_m[k]  = (cnt_m[k] + 1) & mask_m[k];
            pend_m[k] = 1'b0;
            free_m[k] = edge_no + 1;
        end else if (!pend_m[k] && edge_no >= free_m[k] && (rd[k] || ru[k])) begin
            down        = rd[k] && !(ru[k] && last_m[k]);
            dir_m[k]    = down;
            last_m[k]   = down;
            e.data      = down ? b1[k] : b2[k];
            e.due       = edge_no + lat_m[k] - 1;
            pend_m[k]   = 1'b1;
            pend_due[k] = e.due;
            sb[k].push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_no++;
        for (int k = 0; k < N; k++) model_edge(k);
        #1;
    endtask

    // Monitor: every cycle, every instance; pops the scoreboard on the predicted broadcast cycle.
    always @(negedge clk) begin
        logic [31:0] cv;
        bit          due;
        exp_t        e;
        for (int k = 0; k < N; k++) begin
            cv  = (k == 0) ? 32'(cnt0) : (k == 1) ? 32'(cnt1) : 32'(cnt2);
            due = (sb[k].size() > 0) && (sb[k][0].due == edge_no);
            chk("done", k, 32'(done_o[k]), 32'(due));
            chk("busy", k, 32'(busy_o[k]), 32'(sb[k].size() > 0));
            chk("dir_q", k, 32'(dir_o[k]), 32'(dir_m[k]));
            chk("xfer_cnt", k, cv, 32'(cnt_m[k]));
            if (due) begin
                e = sb[k].pop_front();
                chk("bus1_bcast", k, o1[k], e.data);
                chk("bus2_bcast", k, o2[k], e.data);
            end else begin
                chk("bus1_pass", k, o1[k], b1[k]);
                chk("bus2_pass", k, o2[k], b2[k]);
            end
        end
    end

    int cnt_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        logic [1:0] r;
        for (int k = 0; k < N; k++) begin
            rn[k] = 1'b1;
            rd[k] = 1'b0;
            ru[k] = 1'b0;
            b1[k] = 32'hAAAA0001;
            b2[k] = 32'h55550002;
        end
        #2;
        for (int k = 0; k < N; k++) reset_model(k);
        #1;
        chk("rst_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rst_cnt", 0, 32'(cnt0), 32'd0);
        chk("rst_pass1", 0, o1[0], 32'hAAAA0001);
        chk("rst_pass2", 0, o2[0], 32'h55550002);
        repeat (3) tick();
        for (int k = 0; k < N; k++) rn[k] = 1'b1;
        tick();

        // LAT=1 down transfer; the source changes right after capture.
        b1[0] = 32'hDEADBEEF;
        rd[0] = 1'b1;
        tick();
        rd[0] = 1'b0;
        b1[0] = 32'h0;
        #1;
        chk("l1_done", 0, 32'(done_o[0]), 32'd1);
        chk("l1_bus2", 0, o2[0], 32'hDEADBEEF);
        chk("l1_bus1", 0, o1[0], 32'hDEADBEEF);
        chk("l1_dir", 0, 32'(dir_o[0]), 32'd1);
        tick();
        chk("l1_cnt", 0, 32'(cnt0), 32'd1);
        tick();

        // LAT=4 up transfer, request held until the broadcast cycle.
        b2[1] = 32'h12345678;
        ru[1] = 1'b1;
        tick();
        repeat (3) tick();
        ru[1] = 1'b0;
        #1;
        chk("l4_done", 1, 32'(done_o[1]), 32'd1);
        chk("l4_bus1", 1, o1[1], 32'h12345678);
        chk("l4_dir", 1, 32'(dir_o[1]), 32'd0);
        tick();
        tick();

        // Both requests held from reset on LAT=1: down, up, down, up.
        reset_model(0);
        rd[0] = 1'b1;
        ru[0] = 1'b1;
        b1[0] = 32'h11110000;
        b2[0] = 32'h22220000;
        tick();
        rn[0] = 1'b1;
        repeat (8) tick();
        rd[0] = 1'b0;
        ru[0] = 1'b0;
        chk("rr_cnt4", 0, 32'(cnt0), 32'd4);
        chk("rr_last_up", 0, 32'(dir_o[0]), 32'd0);
        tick();
        tick();

        // 2-bit counter wraps over five transfers.
        for (int i = 0; i < 5; i++) begin
            b1[2] = $urandom;
            rd[2] = 1'b1;
            tick();
            rd[2] = 1'b0;
            repeat (3) tick();
            chk("cnt_wrap", 2, 32'(cnt2), 32'(cnt_seq[i]));
        end
        tick();

        // Reset in the second XFER cycle of a LAT=4 transfer, then a clean transfer.
        b1[1] = 32'hCAFEF00D;
        rd[1] = 1'b1;
        tick();
        tick();
        reset_model(1);
        #1;
        chk("mid_rst_pass", 1, o1[1], 32'hCAFEF00D);
        chk("mid_rst_busy", 1, 32'(busy_o[1]), 32'd0);
        chk("mid_rst_cnt", 1, 32'(cnt1), 32'd0);
        rd[1] = 1'b0;
        tick();
        rn[1] = 1'b1;
        tick();
        b1[1] = 32'h0BADF00D;
        rd[1] = 1'b1;
        tick();
        repeat (3) tick();
        rd[1] = 1'b0;
        #1;
        chk("post_rst_done", 1, 32'(done_o[1]), 32'd1);
        chk("post_rst_bus2", 1, o2[1], 32'h0BADF00D);
        tick();
        chk("post_rst_cnt", 1, 32'(cnt1), 32'd1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!rn[k]) rn[k] = 1'b1;
                else if ($urandom_range(199) == 0) reset_model(k);
                b1[k] = $urandom;
                b2[k] = $urandom;
                r     = 2'($urandom_range(3));
                rd[k] = r[0];
                ru[k] = r[1];
            end
            tick();
        end

        // Drain: every predicted broadcast must have been consumed.
        for (int k = 0; k < N; k++) begin
            rn[k] = 1'b1;
            rd[k] = 1'b0;
            ru[k] = 1'b0;
        end
        repeat (12) tick();
        for (int k = 0; k < N; k++) chk("drain_empty", k, 32'(sb[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_bridge_xfer.md
Name: bus_bridge_xfer

Overview:
- Registered, arbitrated bridge between two bus segments in the multi-cycle CPU datapath.
- Successor to the combinational enable/direction bridge: width is parametrised, and data is captured into a holding register.
- Data is released to both sides after a programmable latency, with one exclusive broadcast cycle per transfer.
- Adds request arbitration, busy/done status and a transfer counter for the control unit.

Parameters:
WIDTH, 32, data width of each bus segment
LAT, 1, cycles from capture edge to broadcast cycle; legal 1..8
CNT_W, 16, width of the completed-transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bus1_in  input  WIDTH  upper segment data
bus2_in  input  WIDTH  lower segment data
req_down  input  1  request transfer bus1 -> bus2
req_up  input  1  request transfer bus2 -> bus1
bus1_out  output  WIDTH  upper segment drive
bus2_out  output  WIDTH  lower segment drive
busy  output  1  transfer in flight (XFER or DONE)
done  output  1  one-cycle pulse, broadcast cycle
dir_q  output  1  direction of current/last transfer: 1 = down, 0 = up
xfer_cnt  output  CNT_W  completed transfers, wraps

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; data_q = 0; wait counter = 0.
  - dir_q = 0; last_grant = up; busy = 0; done = 0; xfer_cnt = 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - Outputs pass through: bus1_out = bus1_in, bus2_out = bus2_in.
  - At a clock edge with any request, the bridge grants one request and moves out of IDLE.
  - req_down only: data_q <= bus1_in, dir_q <= 1.
  - req_up only: data_q <= bus2_in, dir_q <= 0.
  - Both requests: grant the direction opposite to last_grant (round robin). After reset the first simultaneous grant is down.
  - Grant sets last_grant to the granted direction.
  - Next state: XFER if LAT > 1, else DONE. Wait counter loads LAT-2.
- XFER:
  - Outputs pass through, busy = 1.
  - Wait counter decrements each cycle; at 0 the next state is DONE.
  - Total XFER residency is LAT-1 cycles.
- DONE:
  - Exactly one cycle, busy = 1, done = 1.
  - bus1_out = bus2_out = data_q; both segments see the transferred word.
  - xfer_cnt increments at the exiting edge, wrapping from 2^CNT_W-1 to 0.
  - Next state is IDLE.
- Latency:
  - done is high in the LAT-th cycle after the capture edge.
  - A new capture is possible at the edge ending DONE +1, i.e. IDLE lasts at least one cycle between transfers.
  - Back-to-back throughput is one transfer per LAT+1 cycles.
- Requests are level-sensitive and sampled only in IDLE.
  - Requests during XFER/DONE are ignored, not queued; requesters hold the level until done.
  - The ungranted request of a simultaneous pair is served next if it is still held.
- data_q is stable from capture until the next capture. Input changes after the capture edge do not affect the broadcast value.
- busy and done are decoded from the registered state (glitch-free).
- dir_q holds its value after DONE until the next grant.
- Reset asserted mid-transfer:
  - Outputs return to pass-through immediately and the transfer is dropped.
  - xfer_cnt is cleared and no done pulse is issued.
- Counter overflow is silent; no sticky flag.

Test Plan:
- Reset, LAT=1: bus1_in=0xAAAA0001, bus2_in=0x5555_0002 -> outputs equal inputs; busy=0, done=0, xfer_cnt=0.
- LAT=1, req_down pulse held at edge with bus1_in=0xDEADBEEF, then bus1_in changes to 0 -> next cycle done=1, both outputs 0xDEADBEEF, dir_q=1; following cycle pass-through, xfer_cnt=1.
- LAT=4, req_up with bus2_in=0x12345678 -> busy for cycles 1..4, done only in cycle 4; outputs are pass-through in cycles 1..3 and both 0x12345678 in cycle 4; dir_q=0.
- req_down and req_up held together from reset, LAT=1 -> grants alternate down, up, down, up; done every 2 cycles; xfer_cnt=4 after 8 cycles.
- CNT_W=2: five transfers -> xfer_cnt sequence 1,2,3,0,1.
- LAT=4: assert rst_n=0 during XFER cycle 2 -> outputs are pass-through the same cycle; busy=0, no done, xfer_cnt=0; a subsequent req_down completes normally.
